rr_bus_mux: RTL and testbench

Parametrised, registered N-to-1 bus multiplexer with valid/ready handshaking. It is the successor to the datapath's fixed 4:1 combinational 16-bit mux. Selection is either fixed, driven by a select line, or round-robin arbitration across requesting sources. The selected word lands in a single-entry output register, which breaks the long combinational path from the source units onto the shared bus.

---
 rtl/rr_bus_mux_if.sv | 38 +++
 rtl/rr_bus_mux.sv | 111 +++++++++++
 tb/tb_rr_bus_mux.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rr_bus_mux_if.sv
// Bus bundle for rr_bus_mux: N source channels in, one registered word out.
// The slave modport is the multiplexer's view; master is the environment's.
// out_parity exists only when RR_BUS_MUX_PARITY_EN is defined.
interface rr_bus_mux_if #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic                    mode;
  logic [SEL_W-1:0]        select;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;
`ifdef RR_BUS_MUX_PARITY_EN
  logic                    out_parity;
`endif

  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_src, out_valid
`ifdef RR_BUS_MUX_PARITY_EN
    , output out_parity
`endif
  );

  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_src, out_valid
`ifdef RR_BUS_MUX_PARITY_EN
    , input out_parity
`endif
  );
endinterface

// File: rtl/rr_bus_mux.sv
// rr_bus_mux: registered NUM_IN-to-1 bus multiplexer with valid/ready handshake.
// Selection is either a fixed select index (mode = 0) or round-robin
// arbitration starting at r_rr_ptr (mode = 1). The chosen word lands in a
// single-entry output register that reloads without a bubble when consumed.
// Optional feature: define RR_BUS_MUX_PARITY_EN to add a registered even-parity
// bit (out_parity) alongside out_data.
module rr_bus_mux #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4
) (
  input  logic          clk,
  input  logic          reset,
  rr_bus_mux_if.slave   bus
);
  localparam int SEL_W = $clog2(NUM_IN);

  logic              w_load_en;
  logic              w_grant_vld;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [NUM_IN-1:0] w_in_ready;
  logic [WIDTH-1:0]  w_grant_data;

  logic [SEL_W-1:0]  r_rr_ptr;
  logic [WIDTH-1:0]  r_out_data;
  logic [SEL_W-1:0]  r_out_src;
  logic              r_out_valid;
`ifdef RR_BUS_MUX_PARITY_EN
  logic              r_out_parity;
`endif

  // The register can take a word when it is empty or is being drained now.
  assign w_load_en = !r_out_valid || bus.out_ready;

  // Arbitration: pick the granted channel from in_valid, mode, select and the pointer.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    if (!bus.mode) begin
      // Comparing against each legal index means select >= NUM_IN never grants.
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.select == SEL_W'(i) && bus.in_valid[i]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SEL_W'(i);
        end
      end
    end else begin
      // Scan r_rr_ptr, r_rr_ptr+1, ... wrapping; the first requester wins.
      for (int k = 0; k < NUM_IN; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (!w_grant_vld && bus.in_valid[idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = SEL_W'(idx);
        end
      end
    end
  end

  // One-hot accept toward the granted source, gated by output-register space.
  always_comb begin
    w_in_ready = '0;
    if (w_grant_vld) w_in_ready[w_grant_idx] = w_load_en;
  end

  assign w_grant_data = bus.in_data[int'(w_grant_idx)*WIDTH +: WIDTH];

  // Output register: load on transfer, empty when drained with no grant, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= '0;
`ifdef RR_BUS_MUX_PARITY_EN
      r_out_parity <= 1'b0;
`endif
    end else if (w_load_en) begin
      r_out_valid <= w_grant_vld;
      if (w_grant_vld) begin
        r_out_data   <= w_grant_data;
        r_out_src    <= w_grant_idx;
`ifdef RR_BUS_MUX_PARITY_EN
        r_out_parity <= ^w_grant_data;
`endif
      end
    end
  end

  // Round-robin pointer: moves past the winner only on a round-robin transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_load_en && w_grant_vld && bus.mode) begin
      if (int'(w_grant_idx) == NUM_IN - 1) r_rr_ptr <= '0;
      else                                 r_rr_ptr <= w_grant_idx + 1'b1;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_data   = r_out_data;
  assign bus.out_src    = r_out_src;
  assign bus.out_valid  = r_out_valid;
`ifdef RR_BUS_MUX_PARITY_EN
  assign bus.out_parity = r_out_parity;
`endif
endmodule

// File: tb/tb_rr_bus_mux.sv
// Self-checking bench for rr_bus_mux (WIDTH=16, NUM_IN=4). A driver applies
// each cycle's stimulus, predicts in_ready and any accepted word from a
// behavioural model, and queues expected words; a monitor compares the
// output register against the queue whenever out_valid is high.
module tb_rr_bus_mux;
  localparam int WIDTH  = 16;
  localparam int NUM_IN = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               src;
    logic             par;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  // Model state: output register occupancy and round-robin pointer.
  bit   m_valid;
  int   m_ptr;

  rr_bus_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

  rr_bus_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; inputs applied just after a rising edge.
  task automatic cycle(input logic [3:0] v, input logic m, input logic [1:0] s,
                       input logic ordy, input logic [63:0] d);
    int   g;
    bit   load_en;
    logic [3:0] exp_ready;
    logic [WIDTH-1:0] w;
    bus.in_valid  = v;
    bus.mode      = m;
    bus.select    = s;
    bus.out_ready = ordy;
    bus.in_data   = d;
    @(negedge clk);
    // Reference: who should win this cycle.
    g = -1;
    if (m == 1'b0) begin
      if (int'(s) < NUM_IN && v[s]) g = int'(s);
    end else begin
      for (int k = 0; k < NUM_IN; k++)
        if (g < 0 && v[(m_ptr + k) % NUM_IN]) g = (m_ptr + k) % NUM_IN;
    end
    load_en   = !m_valid || ordy;
    exp_ready = (g >= 0 && load_en) ? 4'(1 << g) : 4'b0000;
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (load_en) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        w = d[g*WIDTH +: WIDTH];
        exp_q.push_back('{data: w, src: g, par: ^w});
        if (m) m_ptr = (g + 1) % NUM_IN;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the held/consumed word with the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(bus.out_valid), 64'(0));
      end else begin
        check("out_data", 64'(bus.out_data), 64'(exp_q[0].data));
        check("out_src", 64'(bus.out_src), 64'(exp_q[0].src));
`ifdef RR_BUS_MUX_PARITY_EN
        check("out_parity", 64'(bus.out_parity), 64'(exp_q[0].par));
`endif
        if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] rand_data();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] d;
    n_tests = 0;
    n_fail  = 0;
    m_valid = 0;
    m_ptr   = 0;
    bus.in_valid  = '0;
    bus.mode      = 1'b0;
    bus.select    = '0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  64'(bus.out_data),  64'(0));
    check("rst_out_src",   64'(bus.out_src),   64'(0));
    check("rst_in_ready",  64'(bus.in_ready),  64'(0));

    // Fixed select 2, channel 2 carries 0x1234.
    d = rand_data();
    d[2*WIDTH +: WIDTH] = 16'h1234;
    bus.in_valid = 4'b1111; bus.select = 2'd2; bus.out_ready = 1'b1; bus.in_data = d;
    #1 check("fix_in_ready", 64'(bus.in_ready), 64'(4'b0100));
    cycle(4'b1111, 1'b0, 2'd2, 1'b1, d);
    check("fix_out_data",  64'(bus.out_data),  64'(16'h1234));
    check("fix_out_src",   64'(bus.out_src),   64'(2));
    check("fix_out_valid", 64'(bus.out_valid), 64'(1));

    // Fixed select on a channel that is not requesting.
    repeat (3) cycle(4'b1101, 1'b0, 2'd1, 1'b1, rand_data());
    check("norq_out_valid", 64'(bus.out_valid), 64'(0));

    // Round-robin with every channel requesting: 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1, 2'd0, 1'b1, rand_data());
      check("rr_seq_src", 64'(bus.out_src), 64'(i % NUM_IN));
    end

    // Backpressure for three cycles, then release.
    repeat (3) cycle(4'b1111, 1'b1, 2'd0, 1'b0, rand_data());
    repeat (2) cycle(4'b1111, 1'b1, 2'd0, 1'b1, rand_data());

    // Asynchronous reset between edges while a word is held.
    check("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    #1 reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_data",  64'(bus.out_data),  64'(0));
    exp_q.delete();
    m_valid = 0;
    m_ptr   = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(4'b1111, 1'b1, 2'd0, 1'b1, rand_data());
    check("rr_restart_src", 64'(bus.out_src), 64'(0));

`ifdef RR_BUS_MUX_PARITY_EN
    cycle(4'b0001, 1'b0, 2'd0, 1'b1, 64'h0000_0000_0000_0007);
    check("parity_0007", 64'(bus.out_parity), 64'(1));
    cycle(4'b0001, 1'b0, 2'd0, 1'b1, 64'h0000_0000_0000_0003);
    check("parity_0003", 64'(bus.out_parity), 64'(0));
`endif

    // Randomised traffic across both modes, all select values and backpressure.
    for (int i = 0; i < 500; i++) begin
      cycle(4'($urandom()), 1'($urandom()), 2'($urandom()),
            ($urandom_range(0, 3) != 0), rand_data());
    end

    // Drain and confirm every accepted word was observed.
    repeat (3) cycle(4'b0000, 1'b0, 2'd0, 1'b1, rand_data());
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("final_out_valid", 64'(bus.out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
